// File: rtl/alu_issue_seq.sv
// Issue sequencer: FIFO-buffers {opcode, A, B}, issues one op at a time, and presents the ALU result on valid/ready.
// Optional ALU_SEQ_CNT_EN adds a saturating handshake counter output op_count.
module alu_issue_seq #(
  parameter int DEPTH   = 4,
  parameter int OP_W    = 4,
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_opcode,
  output logic [DATA_W-1:0] out_result
`ifdef ALU_SEQ_CNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [OP_W-1:0] NOP_OP = OP_W'(7);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state, state_nx;

  logic [OP_W-1:0]   mem_op [DEPTH];
  logic [DATA_W-1:0] mem_a  [DEPTH];
  logic [DATA_W-1:0] mem_b  [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [WW-1:0]     wcnt;
  logic              push, pop, capture, release_out, not_empty;

  // Full check uses the registered count only, so a same-cycle pop never frees a slot.
  assign in_ready  = (count != CW'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = in_valid & in_ready;

  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (not_empty) begin
          pop      = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt == WAIT_LAST) begin
          capture  = 1'b1;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          if (not_empty) begin
            pop      = 1'b1;
            state_nx = S_WAIT;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr] <= in_opcode;
      mem_a[wr_ptr]  <= in_a;
      mem_b[wr_ptr]  <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode <= NOP_OP;
      alu_a  <= '0;
      alu_b  <= '0;
      wcnt   <= '0;
    end else if (pop) begin
      opcode <= mem_op[rd_ptr];
      alu_a  <= mem_a[rd_ptr];
      alu_b  <= mem_b[rd_ptr];
      wcnt   <= '0;
    end else if (state == S_WAIT) begin
      wcnt <= wcnt + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_opcode <= '0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_opcode <= opcode;
    end else if (release_out) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != '1)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Testbench for alu_issue_seq: one-stage ALU model in front of the DUT, queue-based scoreboard of expected results.
module tb_alu_issue_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_opcode = '0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [3:0] opcode;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_result = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_opcode;
  logic [7:0] out_result;

  typedef struct {
    logic [3:0] op;
    logic [7:0] res;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  alu_issue_seq #(.DEPTH(4), .OP_W(4), .DATA_W(8), .ALU_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .opcode(opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_result(out_result)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op[1:0])
      2'd0:    return a ^ b;
      2'd1:    return a - b;
      2'd2:    return a + b;
      default: return a & b;
    endcase
  endfunction

  // ALU result becomes valid one edge after the operand registers change, so it is sampled on the second edge.
  always @(posedge clk) alu_result <= alu_f(opcode, alu_a, alu_b);

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || opcode !== 4'h7 || alu_a !== 8'h00 || alu_b !== 8'h00 ||
        out_result !== 8'h00 || out_opcode !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b op=%h a=%h b=%h res=%h oop=%h, want 1 0 7 00 00 00 0",
               in_ready, out_valid, opcode, alu_a, alu_b, out_result, out_opcode);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 4'h2; in_a = 8'h05; in_b = 8'h03;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (opcode !== 4'h7) begin
      n_fail++; $display("FAIL single_not_yet_issued: opcode=%h want 7", opcode);
    end
    @(negedge clk);
    n_checks++;
    if (opcode !== 4'h2 || alu_a !== 8'h05 || alu_b !== 8'h03 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue: op=%h a=%h b=%h vld=%b want 2 05 03 0", opcode, alu_a, alu_b, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early_valid: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 8'h08 || out_opcode !== 4'h2) begin
      n_fail++;
      $display("FAIL single_result: vld=%b res=%h oop=%h want 1 08 2", out_valid, out_result, out_opcode);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_release: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || opcode !== 4'h7 || out_result !== 8'h00 || out_opcode !== 4'h0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vld=%b op=%h res=%h oop=%h want 1 0 7 00 0",
               in_ready, out_valid, opcode, out_result, out_opcode);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives n requests (sequential pattern or random), scoreboards every handshake, runs until the queue drains.
  task automatic run_stream(input int n, input bit rnd, output int cycles);
    int idx = 0;
    int cyc = 0;
    logic [3:0] op;
    logic [7:0] a, b;
    while ((idx < n || q.size() != 0) && cyc < 2000) begin
      if (idx < n) begin
        if (rnd) begin
          op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
          in_valid = ($urandom_range(0, 9) < 7);
        end else begin
          op = idx[3:0]; a = idx[7:0]; b = 8'(2 * idx);
          in_valid = 1'b1;
        end
        in_opcode = op; in_a = a; in_b = b;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream_unexpected: op=%h res=%h with nothing outstanding", out_opcode, out_result);
        end else begin
          if (out_opcode !== q[0].op || out_result !== q[0].res) begin
            n_fail++;
            $display("FAIL stream_result: op=%h res=%h want op=%h res=%h", out_opcode, out_result, q[0].op, q[0].res);
          end
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{op: in_opcode, res: alu_f(in_opcode, in_a, in_b)});
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL stream_timeout: %0d results outstanding, %0d of %0d pushed", q.size(), idx, n);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycles = cyc;
  endtask

  // Pushes k random requests with out_ready low; accepted ones go to the scoreboard.
  task automatic fill(input int k);
    int acc = 0;
    int cyc = 0;
    out_ready = 1'b0;
    while (acc < k && cyc < 20) begin
      in_valid = 1'b1; in_opcode = 4'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      if (in_ready) begin
        q.push_back('{op: in_opcode, res: alu_f(in_opcode, in_a, in_b)});
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (acc < k) begin
      n_checks++; n_fail++; $display("FAIL fill_timeout: accepted %0d want %0d", acc, k);
    end
  endtask

  task automatic test_fill_full();
    int cyc;
    fill(5);
    in_valid = 1'b1; in_opcode = 4'hC; in_a = 8'h11; in_b = 8'h22;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_opcode !== q[0].op || out_result !== q[0].res) begin
        n_fail++;
        $display("FAIL full_stall: rdy=%b vld=%b oop=%h res=%h want 0 1 %h %h",
                 in_ready, out_valid, out_opcode, out_result, q[0].op, q[0].res);
      end
      @(negedge clk);
    end
    run_stream(1, 1'b0, cyc);
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    fill(2);
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== q[0].res || out_opcode !== q[0].op || opcode !== q[0].op) begin
        n_fail++;
        $display("FAIL backpressure_hold: vld=%b res=%h oop=%h op=%h want 1 %h %h %h",
                 out_valid, out_result, out_opcode, opcode, q[0].res, q[0].op, q[0].op);
      end
      @(negedge clk);
    end
    run_stream(0, 1'b0, cyc);
  endtask

  task automatic test_wrap_order();
    int cyc;
    run_stream(12, 1'b0, cyc);
    n_checks++;
    if (cyc != 3 * 12 + 2) begin
      n_fail++; $display("FAIL back_to_back_rate: took %0d cycles want %0d", cyc, 3 * 12 + 2);
    end
  endtask

  task automatic test_random();
    int cyc;
    run_stream(60, 1'b1, cyc);
  endtask

  task automatic test_reset_mid_wait();
    fill(5);
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== q[0].res || out_opcode !== q[0].op) begin
      n_fail++;
      $display("FAIL rstwait_first: vld=%b res=%h oop=%h want 1 %h %h", out_valid, out_result, out_opcode, q[0].res, q[0].op);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || opcode !== 4'h7) begin
      n_fail++; $display("FAIL rstwait_async: rdy=%b vld=%b op=%h want 1 0 7", in_ready, out_valid, opcode);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rstwait_ghost: vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_op();
    test_async_reset();
    test_fill_full();
    test_backpressure();
    test_wrap_order();
    test_random();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
